pdp8i_timing_ctl: RTL and testbench

Memory-cycle timing and run controller for the PDP-8/I processor model. Sequences each memory cycle through time states TS1–TS4, emits one-clock TP1–TP4 pulses that clock the register/bus-driver logic, and owns the RUN flip-flop: console keys, HLT and single step/instruction. The processor datapath (gate and driver modules) is clocked from these outputs; nothing else generates cycle timing.

---
 rtl/pdp8i_timing_pkg.sv | 32 +++
 rtl/pdp8i_key_edge.sv | 31 +++
 rtl/pdp8i_timing_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_pdp8i_timing_ctl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8i_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdp8i_timing_pkg
// Purpose  : Shared types and constants for the PDP-8/I memory-cycle timing
//            and run controller.
// Revision : 1.0 - initial release
// ============================================================================
package pdp8i_timing_pkg;

    // Width of the per-time-state tick counter
    localparam int c_tick_w = 8;

    // Number of time states / time pulses in one memory cycle
    localparam int c_num_ts = 4;

    // Bit positions of each time state inside the ts/tp vectors
    localparam int c_ts1_idx = 0;
    localparam int c_ts2_idx = 1;
    localparam int c_ts3_idx = 2;
    localparam int c_ts4_idx = 3;

    // Controller state: idle, or one of the four time states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TS1  = 3'd1,
        S_TS2  = 3'd2,
        S_TS3  = 3'd3,
        S_TS4  = 3'd4
    } state_t;

endpackage : pdp8i_timing_pkg
`default_nettype wire

// File: rtl/pdp8i_key_edge.sv
`default_nettype none
// ============================================================================
// Module   : pdp8i_key_edge
// Purpose  : Rising-edge detector for one console key level. The previous
//            sample is registered; a key held high fires exactly once.
// Revision : 1.0 - initial release
// ============================================================================
module pdp8i_key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_rise
);

    logic r_prev;

    // Remember last sampled key level so a held key cannot retrigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_key;
        end
    end

    // Edge is consumed by the controller's register stage, so no output path
    // leaves the controller combinationally
    assign o_rise = i_key & ~r_prev;

endmodule : pdp8i_key_edge
`default_nettype wire

// File: rtl/pdp8i_timing_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pdp8i_timing_ctl
// Purpose  : Memory-cycle timing and RUN control for the PDP-8/I model.
//            Steps TS1..TS4, emits one-clock TP1..TP4 pulses on the last
//            clock of each time state, stretches TS3 for slow I/O and owns
//            the RUN flip-flop (START/CONT/STOP, HLT, single step/inst).
// Revision : 1.0 - initial release
// ============================================================================
module pdp8i_timing_ctl
    import pdp8i_timing_pkg::*;
#(
    parameter int unsigned TS1_TICKS = 8,
    parameter int unsigned TS2_TICKS = 8,
    parameter int unsigned TS3_TICKS = 8,
    parameter int unsigned TS4_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_start,
    input  logic                key_cont,
    input  logic                key_stop,
    input  logic                sing_step,
    input  logic                sing_inst,
    input  logic                halt_req,
    input  logic                last_cycle,
    input  logic                slow_cycle,
    output logic                run,
    output logic [c_num_ts-1:0] ts,
    output logic [c_num_ts-1:0] tp,
    output logic                mem_start,
    output logic                init
);

    generate
        if (TS1_TICKS == 0 || TS1_TICKS > 255) begin : g_bad_ts1
            $error("TS1_TICKS must be in 1..255");
        end
        if (TS2_TICKS == 0 || TS2_TICKS > 255) begin : g_bad_ts2
            $error("TS2_TICKS must be in 1..255");
        end
        if (TS3_TICKS == 0 || TS3_TICKS > 255) begin : g_bad_ts3
            $error("TS3_TICKS must be in 1..255");
        end
        if (TS4_TICKS == 0 || TS4_TICKS > 255) begin : g_bad_ts4
            $error("TS4_TICKS must be in 1..255");
        end
    endgenerate

    localparam logic [c_tick_w-1:0] c_ts1_ticks = c_tick_w'(TS1_TICKS);
    localparam logic [c_tick_w-1:0] c_ts2_ticks = c_tick_w'(TS2_TICKS);
    localparam logic [c_tick_w-1:0] c_ts3_ticks = c_tick_w'(TS3_TICKS);
    localparam logic [c_tick_w-1:0] c_ts4_ticks = c_tick_w'(TS4_TICKS);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);

    // Dwell length loaded into the counter on entry to a time state
    function automatic logic [c_tick_w-1:0] f_ticks(input state_t s);
        case (s)
            S_TS1:   return c_ts1_ticks;
            S_TS2:   return c_ts2_ticks;
            S_TS3:   return c_ts3_ticks;
            S_TS4:   return c_ts4_ticks;
            default: return '0;
        endcase
    endfunction

    // One-hot time-state vector for a state (zero when idle)
    function automatic logic [c_num_ts-1:0] f_onehot(input state_t s);
        logic [c_num_ts-1:0] v;
        v = '0;
        case (s)
            S_TS1:   v[c_ts1_idx] = 1'b1;
            S_TS2:   v[c_ts2_idx] = 1'b1;
            S_TS3:   v[c_ts3_idx] = 1'b1;
            S_TS4:   v[c_ts4_idx] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Time pulse for the clock about to begin: only on the state's final
    // clock, and TP3 is held back while the I/O pause is asserted
    function automatic logic [c_num_ts-1:0] f_tp(input state_t s,
                                                 input logic [c_tick_w-1:0] cnt,
                                                 input logic slow);
        logic [c_num_ts-1:0] v;
        v = '0;
        if (cnt == c_tick_one) begin
            case (s)
                S_TS1:   v[c_ts1_idx] = 1'b1;
                S_TS2:   v[c_ts2_idx] = 1'b1;
                S_TS3:   v[c_ts3_idx] = ~slow;
                S_TS4:   v[c_ts4_idx] = 1'b1;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    state_t                r_state;
    logic [c_tick_w-1:0]   r_cnt;
    logic                  r_run;
    logic [c_num_ts-1:0]   r_ts;
    logic [c_num_ts-1:0]   r_tp;
    logic                  r_mem_start;
    logic                  r_init;

    logic                  w_start_rise;
    logic                  w_cont_rise;
    logic                  w_stop;
    logic                  w_done;
    logic [c_tick_w-1:0]   w_cnt_dec;
    state_t                w_next;
    logic [c_tick_w-1:0]   w_next_ticks;

    pdp8i_key_edge u_start_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_key  (key_start),
        .o_rise (w_start_rise)
    );

    pdp8i_key_edge u_cont_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_key  (key_cont),
        .o_rise (w_cont_rise)
    );

    assign w_stop = key_stop | halt_req | sing_step | (sing_inst & last_cycle);

    // The clock just ending was the last of its time state once its pulse
    // went out; a withheld TP3 keeps the counter parked at one
    assign w_done = (r_cnt == c_tick_one) &&
                    ((r_state != S_TS3) || r_tp[c_ts3_idx]);

    // Counter never wraps: it parks at one during a TS3 stretch
    assign w_cnt_dec = (r_cnt > c_tick_one) ? (r_cnt - c_tick_one) : r_cnt;

    // Successor time state in the fixed TS1->TS2->TS3->TS4->TS1 ring
    always_comb begin
        w_next = S_TS1;
        case (r_state)
            S_TS1:   w_next = S_TS2;
            S_TS2:   w_next = S_TS3;
            S_TS3:   w_next = S_TS4;
            default: w_next = S_TS1;
        endcase
        w_next_ticks = f_ticks(w_next);
    end

    // Cycle sequencer and RUN flip-flop; every output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_run       <= 1'b0;
            r_ts        <= '0;
            r_tp        <= '0;
            r_mem_start <= 1'b0;
            r_init      <= 1'b0;
        end else begin
            r_tp        <= '0;
            r_mem_start <= 1'b0;
            r_init      <= 1'b0;
            if (r_state == S_IDLE) begin
                if ((w_start_rise || w_cont_rise) && !key_stop) begin
                    r_run       <= 1'b1;
                    r_mem_start <= 1'b1;
                    r_init      <= w_start_rise;
                    r_state     <= S_TS1;
                    r_cnt       <= c_ts1_ticks;
                    r_ts        <= f_onehot(S_TS1);
                    r_tp        <= f_tp(S_TS1, c_ts1_ticks, slow_cycle);
                end
            end else if (!w_done) begin
                r_cnt <= w_cnt_dec;
                r_tp  <= f_tp(r_state, w_cnt_dec, slow_cycle);
            end else if ((r_state == S_TS4) && w_stop) begin
                r_run   <= 1'b0;
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_ts    <= '0;
            end else begin
                r_state     <= w_next;
                r_cnt       <= w_next_ticks;
                r_ts        <= f_onehot(w_next);
                r_tp        <= f_tp(w_next, w_next_ticks, slow_cycle);
                r_mem_start <= (w_next == S_TS1);
            end
        end
    end

    assign run       = r_run;
    assign ts        = r_ts;
    assign tp        = r_tp;
    assign mem_start = r_mem_start;
    assign init      = r_init;

endmodule : pdp8i_timing_ctl
`default_nettype wire

// File: tb/tb_pdp8i_timing_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp8i_timing_ctl
// Purpose  : Self-checking bench for pdp8i_timing_ctl. A reference model
//            tracks the cycle as "phase number + clocks spent in phase" and
//            queues expected pulse events; a monitor pops them whenever the
//            DUT emits a pulse. Directed scenarios add absolute offsets.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pdp8i_timing_ctl;

    localparam int T1 = 8;
    localparam int T2 = 8;
    localparam int T3 = 8;
    localparam int T4 = 8;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       key_start  = 1'b0;
    logic       key_cont   = 1'b0;
    logic       key_stop   = 1'b0;
    logic       sing_step  = 1'b0;
    logic       sing_inst  = 1'b0;
    logic       halt_req   = 1'b0;
    logic       last_cycle = 1'b0;
    logic       slow_cycle = 1'b0;
    logic       run;
    logic [3:0] ts;
    logic [3:0] tp;
    logic       mem_start;
    logic       init;

    always #5 clk = ~clk;

    pdp8i_timing_ctl #(
        .TS1_TICKS (T1),
        .TS2_TICKS (T2),
        .TS3_TICKS (T3),
        .TS4_TICKS (T4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_start  (key_start),
        .key_cont   (key_cont),
        .key_stop   (key_stop),
        .sing_step  (sing_step),
        .sing_inst  (sing_inst),
        .halt_req   (halt_req),
        .last_cycle (last_cycle),
        .slow_cycle (slow_cycle),
        .run        (run),
        .ts         (ts),
        .tp         (tp),
        .mem_start  (mem_start),
        .init       (init)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         c;
        logic [3:0] tp;
        logic       ms;
        logic       in;
    } ev_t;

    ev_t q[$];

    // Reference model state: phase 0 = idle, 1..4 = TS1..TS4
    int   ticks[5] = '{0, T1, T2, T3, T4};
    int   m_phase  = 0;
    int   m_pos    = 0;
    logic m_run    = 1'b0;
    logic m_ks     = 1'b0;
    logic m_kc     = 1'b0;
    logic m_end    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of the reference model, applied at each rising edge
    task automatic model_step();
        logic       se, ce, stop, ems, ein;
        logic [3:0] etp;
        ev_t        e;
        se   = key_start && !m_ks;
        ce   = key_cont && !m_kc;
        m_ks = key_start;
        m_kc = key_cont;
        stop = key_stop || halt_req || sing_step || (sing_inst && last_cycle);
        etp  = '0;
        ems  = 1'b0;
        ein  = 1'b0;
        if (m_phase == 0) begin
            if ((se || ce) && !key_stop) begin
                m_phase = 1;
                m_pos   = 0;
                m_run   = 1'b1;
                ems     = 1'b1;
                ein     = se;
            end
        end else if (m_end) begin
            if (m_phase == 4) begin
                if (stop) begin
                    m_phase = 0;
                    m_run   = 1'b0;
                end else begin
                    m_phase = 1;
                    m_pos   = 0;
                    ems     = 1'b1;
                end
            end else begin
                m_phase = m_phase + 1;
                m_pos   = 0;
            end
        end else begin
            m_pos = m_pos + 1;
        end
        if (m_phase != 0 && m_pos >= ticks[m_phase] - 1 && !(m_phase == 3 && slow_cycle))
            etp[m_phase-1] = 1'b1;
        m_end = (etp != 4'b0);
        cyc   = cyc + 1;
        if (etp != 4'b0 || ems || ein) begin
            e.c  = cyc;
            e.tp = etp;
            e.ms = ems;
            e.in = ein;
            q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0;
                m_pos   = 0;
                m_run   = 1'b0;
                m_ks    = 1'b0;
                m_kc    = 1'b0;
                m_end   = 1'b0;
                q.delete();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: state every clock, pulses popped from the scoreboard
    initial begin
        ev_t        e;
        logic [3:0] exp_ts;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_ts = (m_phase == 0) ? 4'b0 : (4'b1 << (m_phase - 1));
                check("state_run_ts", int'({run, ts}), int'({m_run, exp_ts}));
                if (tp != 4'b0 || mem_start || init) begin
                    if (q.size() == 0) begin
                        check("sb_unexpected_pulse", int'({tp, mem_start, init}), 0);
                    end else begin
                        e = q.pop_front();
                        check("sb_cycle", cyc, e.c);
                        check("sb_pulse", int'({tp, mem_start, init}), int'({e.tp, e.ms, e.in}));
                    end
                end
            end
        end
    end

    // which: 0 mem_start, 1 TP4, 2 run low, 3 TP3; returns cycle or -1
    task automatic wait_sig(input int which, input int bound, output int t);
        bit hit;
        t = -1;
        for (int n = 0; n < bound && t < 0; n++) begin
            @(negedge clk);
            case (which)
                0:       hit = mem_start;
                1:       hit = tp[3];
                2:       hit = !run;
                default: hit = tp[2];
            endcase
            if (hit) t = cyc;
        end
        check($sformatf("wait_%0d_in_time", which), int'(t >= 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t, t1;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({run, ts, tp, mem_start, init}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // START from idle with default timing
        key_start = 1'b1;
        wait_sig(0, 5, t0);
        key_start = 1'b0;
        check("start_init", int'({init, mem_start, run}), 3'b111);
        wait_sig(1, 40, t);
        check("start_tp4_offset", t - t0, 31);
        wait_sig(0, 5, t);
        check("start_next_ts1", t - t0, 32);
        t0 = t;

        // STOP raised mid-cycle: cycle completes, then idle
        repeat (9) @(negedge clk);
        key_stop = 1'b1;
        repeat (22) @(negedge clk);
        check("stop_tp4_still_run", int'({run, ts, tp}), 9'b1_1000_1000);
        @(negedge clk);
        check("stop_idle", int'({run, ts, mem_start}), 0);
        key_stop = 1'b0;

        // Single instruction: two-cycle instruction, then one more via CONT
        sing_inst  = 1'b1;
        last_cycle = 1'b0;
        key_cont   = 1'b1;
        wait_sig(0, 5, t0);
        key_cont = 1'b0;
        check("cont_no_init", int'(init), 0);
        wait_sig(0, 40, t1);
        check("sinst_second_cycle", t1 - t0, 32);
        last_cycle = 1'b1;
        wait_sig(2, 40, t);
        check("sinst_halt_at_64", t - t0, 64);
        key_cont = 1'b1;
        wait_sig(0, 5, t0);
        key_cont = 1'b0;
        check("cont2_no_init", int'(init), 0);
        wait_sig(2, 40, t);
        check("sinst_one_cycle", t - t0, 32);
        sing_inst  = 1'b0;
        last_cycle = 1'b0;

        // Slow I/O stretches TS3
        key_start = 1'b1;
        wait_sig(0, 5, t0);
        key_start = 1'b0;
        repeat (19) @(negedge clk);
        slow_cycle = 1'b1;
        repeat (10) @(negedge clk);
        slow_cycle = 1'b0;
        wait_sig(3, 5, t);
        check("slow_tp3_offset", t - t0, 30);
        wait_sig(1, 20, t);
        check("slow_tp4_offset", t - t0, 38);
        wait_sig(0, 5, t);
        check("slow_next_ts1", t - t0, 39);
        key_stop = 1'b1;
        wait_sig(2, 40, t);
        key_stop = 1'b0;

        // START with STOP in idle is suppressed; held START never retriggers
        key_start = 1'b1;
        key_stop  = 1'b1;
        repeat (3) @(negedge clk);
        check("start_with_stop", int'({run, ts}), 0);
        key_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("held_start_idle", int'({run, ts}), 0);
        key_start = 1'b0;
        @(negedge clk);
        key_start = 1'b1;
        wait_sig(0, 5, t0);
        check("repress_init", int'(init), 1);
        halt_req = 1'b1;
        wait_sig(2, 40, t);
        check("halt_after_cycle", t - t0, 32);
        halt_req = 1'b0;
        repeat (5) @(negedge clk);
        check("held_start_after_halt", int'(run), 0);
        key_start = 1'b0;

        // Asynchronous reset during TS2
        @(negedge clk);
        key_start = 1'b1;
        wait_sig(0, 5, t0);
        key_start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_ts2", int'(ts), 4'b0010);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", int'({run, ts, tp, mem_start, init}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", int'({run, ts}), 0);
        key_start = 1'b1;
        wait_sig(0, 5, t0);
        key_start = 1'b0;
        check("post_reset_start", int'({init, run}), 2'b11);
        key_stop = 1'b1;
        wait_sig(2, 40, t);
        key_stop = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            key_start  = ($urandom_range(0, 29) == 0);
            key_cont   = ($urandom_range(0, 29) == 0);
            key_stop   = ($urandom_range(0, 79) == 0);
            halt_req   = ($urandom_range(0, 149) == 0);
            sing_step  = ($urandom_range(0, 199) == 0);
            slow_cycle = ($urandom_range(0, 2) == 0);
            last_cycle = ($urandom_range(0, 1) == 1);
            if (i % 500 == 0) sing_inst = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        key_start  = 1'b0;
        key_cont   = 1'b0;
        key_stop   = 1'b0;
        halt_req   = 1'b0;
        sing_step  = 1'b0;
        slow_cycle = 1'b0;
        sing_inst  = 1'b0;
        repeat (40) @(negedge clk);
        #1 check("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pdp8i_timing_ctl
`default_nettype wire
